// File: rtl/rf_access_arbiter_pkg.sv
// Shared constants and types for the register-file access arbiter.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  localparam logic [1:0] RF_OP_NOP   = 2'd0;
  localparam logic [1:0] RF_OP_WRITE = 2'd1;
  localparam logic [1:0] RF_OP_SWAP  = 2'd2;
  localparam logic [1:0] RF_OP_CLEAR = 2'd3;

  localparam logic [1:0] RF_FLAG_IDLE  = 2'd0;
  localparam logic [1:0] RF_FLAG_WRITE = 2'd1;
  localparam logic [1:0] RF_FLAG_SWAP  = 2'd2;

  typedef enum logic {IDLE, CLEAR} rf_state_e;

endpackage

// File: rtl/rf_access_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_i,
  input  logic             en_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int c;
    c         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr_q) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!gnt_vld_o && en_i && req_i[c]) begin
        gnt_vld_o = 1'b1;
        gnt_o[c]  = 1'b1;
        gnt_idx_o = IDX_W'(c);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_o)
      ptr_d = (gnt_idx_o == IDX_W'(NREQ - 1)) ? '0 : gnt_idx_o + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares the register-file command port among NREQ requesters, incl. range-clear bursts.
// Optional: define RF_ARB_R0_PROTECT_EN to make register 0 read-only.
module rf_access_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  parameter int FLAG_W = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [ADDR_W*NREQ-1:0] req_addr_a,
  input  logic [ADDR_W*NREQ-1:0] req_addr_b,
  input  logic [DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   busy,
  output logic [FLAG_W-1:0]      rf_flag,
  output logic [ADDR_W-1:0]      rf_addr_w,
  output logic [ADDR_W-1:0]      rf_addr_r1,
  output logic [ADDR_W-1:0]      rf_addr_r2,
  output logic [DATA_W-1:0]      rf_data
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef RF_ARB_R0_PROTECT_EN
  localparam bit R0_PROT = 1'b1;
`else
  localparam bit R0_PROT = 1'b0;
`endif

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, end_q, end_d;
  logic [FLAG_W-1:0] flag_q, flag_d;
  logic [ADDR_W-1:0] aw_q, aw_d, r1_q, r1_d, r2_q, r2_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [NREQ-1:0]   cand, gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_vld, arb_en;
  logic [1:0]        op_s;
  logic [ADDR_W-1:0] a_s, b_s, clr_start;
  logic [DATA_W-1:0] d_s;
  logic              a_zero, b_zero;

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      cand[i] = req_valid[i] && (req_op[2*i +: 2] != RF_OP_NOP);
  end

  assign arb_en = (state_q == IDLE) && !reset;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .clock     (clock),
    .reset     (reset),
    .req_i     (cand),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign req_ready = gnt;

  assign op_s   = req_op[int'(gnt_idx)*2 +: 2];
  assign a_s    = req_addr_a[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign b_s    = req_addr_b[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign d_s    = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign a_zero = (a_s == '0);
  assign b_zero = (b_s == '0);
  // With register 0 protected a clear starting at 0 begins at 1; 0..0 then becomes empty.
  assign clr_start = (R0_PROT && a_zero) ? ADDR_W'(1) : a_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    end_d   = end_q;
    flag_d  = FLAG_W'(RF_FLAG_IDLE);
    aw_d    = aw_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          case (op_s)
            RF_OP_WRITE: begin
              if (!(R0_PROT && a_zero)) begin
                flag_d = FLAG_W'(RF_FLAG_WRITE);
                aw_d   = a_s;
                data_d = d_s;
              end
            end
            RF_OP_SWAP: begin
              if (!(R0_PROT && (a_zero || b_zero))) begin
                flag_d = FLAG_W'(RF_FLAG_SWAP);
                r1_d   = a_s;
                r2_d   = b_s;
              end
            end
            RF_OP_CLEAR: begin
              if (clr_start <= b_s) begin
                flag_d = FLAG_W'(RF_FLAG_WRITE);
                aw_d   = clr_start;
                data_d = '0;
                if (clr_start != b_s) begin
                  state_d = CLEAR;
                  cnt_d   = clr_start + 1'b1;
                  end_d   = b_s;
                end
              end
            end
            default: ;
          endcase
        end
      end
      CLEAR: begin
        // Compare before incrementing so an end address of all-ones never wraps.
        flag_d = FLAG_W'(RF_FLAG_WRITE);
        aw_d   = cnt_q;
        data_d = '0;
        if (cnt_q == end_q) state_d = IDLE;
        else                cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      end_q   <= '0;
      flag_q  <= '0;
      aw_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      flag_q  <= flag_d;
      aw_q    <= aw_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      data_q  <= data_d;
    end
  end

  assign busy       = (state_q == CLEAR);
  assign rf_flag    = flag_q;
  assign rf_addr_w  = aw_q;
  assign rf_addr_r1 = r1_q;
  assign rf_addr_r2 = r2_q;
  assign rf_data    = data_q;

endmodule
